// File: rtl/leb128_reader.sv
// LEB128 immediate reader: fetches one ROM byte per cycle and decodes a signed
// or unsigned WebAssembly LEB128 integer, reporting value, length and next PC.
module leb128_reader #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [AW-1:0] pc_in_i,
  input  logic          signed_mode_i,
  output logic [AW-1:0] rom_addr_o,
  output logic [3:0]    rom_extra_o,
  input  logic [7:0]    rom_data_i,
  input  logic          rom_error_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [W-1:0]  value_o,
  output logic [3:0]    len_o,
  output logic [AW-1:0] next_pc_o
);

  localparam int unsigned MAXLEN = (W + 6) / 7;
  // Payload bits actually used in the final permitted byte.
  localparam int unsigned USED   = W - 7 * (MAXLEN - 1);
  localparam int unsigned SHW    = 7;
  localparam int unsigned LW     = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DECODE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            sgn_q, sgn_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [W-1:0]    value_q, value_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   next_pc_q, next_pc_d;

  logic [SHW-1:0]  shamt;
  logic [SHW-1:0]  end_shamt;
  logic [W-1:0]    acc_new;
  logic [W-1:0]    fill;
  logic            last;
  logic            unused_bad;
  logic            finish;
  logic            fail;

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      sgn_q      <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      value_q    <= '0;
      len_q      <= '0;
      next_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sgn_q      <= sgn_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      value_q    <= value_d;
      len_q      <= len_d;
      next_pc_q  <= next_pc_d;
    end
  end

  // Next-state, accumulation and termination/error classification.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sgn_d      = sgn_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    value_d    = value_q;
    len_d      = len_q;
    next_pc_d  = next_pc_q;

    shamt      = SHW'(idx_q) * SHW'(7);
    end_shamt  = shamt + SHW'(7);
    acc_new    = acc_q | (W'(rom_data_i[6:0]) << shamt);
    // Shifts of W or more yield zero, so no sign fill once the value is full.
    fill       = {W{1'b1}} << end_shamt;
    last       = (idx_q == LW'(MAXLEN - 1));
    unused_bad = sgn_q ? !((&rom_data_i[6:USED-1]) || !(|rom_data_i[6:USED-1]))
                       : (|rom_data_i[6:USED]);
    finish     = rom_error_i || !rom_data_i[7] || last;
    fail       = rom_error_i || rom_data_i[7] || (last && unused_bad);

    unique case (state_q)
      IDLE: begin
        if (start_i && !done_q) begin
          pc_d       = pc_in_i;
          sgn_d      = signed_mode_i;
          rom_addr_d = pc_in_i;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        rom_addr_d = rom_addr_q + AW'(1);
        state_d    = DECODE;
      end
      DECODE: begin
        rom_addr_d = rom_addr_q + AW'(1);
        acc_d      = acc_new;
        idx_d      = idx_q + LW'(1);
        if (finish) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          len_d     = idx_q + LW'(1);
          next_pc_d = pc_q + AW'(idx_q + LW'(1));
          if (fail) begin
            error_d = 1'b1;
            value_d = '0;
          end else begin
            value_d = acc_new | ((sgn_q && rom_data_i[6]) ? fill : '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || done_d;
  end

  assign rom_addr_o  = rom_addr_q;
  assign rom_extra_o = 4'd0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign value_o     = value_q;
  assign len_o       = len_q;
  assign next_pc_o   = next_pc_q;

endmodule

// File: tb/tb_leb128_reader.sv
// Directed bench for leb128_reader with a behavioural one-cycle-latency ROM and
// an expected-result scoreboard checked on every done pulse.
module tb_leb128_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  pc_in;
  logic        signed_mode;
  logic [3:0]  rom_addr;
  logic [3:0]  rom_extra;
  logic [7:0]  rom_data;
  logic        rom_error;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] value;
  logic [3:0]  len;
  logic [3:0]  next_pc;

  logic [7:0]  mem [16];
  logic [3:0]  lo_b;
  logic [3:0]  hi_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] value;
    logic [3:0]  len;
    logic [3:0]  npc;
    logic        err;
    int          dcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: address sampled at an edge, data/error returned at that edge.
  always @(posedge clk) begin
    rom_data  <= mem[rom_addr];
    rom_error <= (rom_addr < lo_b) || (rom_addr > hi_b);
  end

  leb128_reader #(.AW(4), .W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start),
    .pc_in_i       (pc_in),
    .signed_mode_i (signed_mode),
    .rom_addr_o    (rom_addr),
    .rom_extra_o   (rom_extra),
    .rom_data_i    (rom_data),
    .rom_error_i   (rom_error),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error),
    .value_o       (value),
    .len_o         (len),
    .next_pc_o     (next_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Pop and compare one expected result per done pulse.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("value",        64'(value),   64'(mon_e.value));
        chk("len",          64'(len),     64'(mon_e.len));
        chk("next_pc",      64'(next_pc), 64'(mon_e.npc));
        chk("error",        64'(error),   64'(mon_e.err));
        chk("done_cycle",   64'(cyc),     64'(mon_e.dcyc));
        chk("busy_at_done", 64'(busy),    64'd1);
      end
    end
  end

  // poke: 0 none, 1 extra start while busy, 2 start during the done cycle.
  task automatic run(input logic [3:0] pc, input logic sgn, input logic [31:0] ev,
                     input logic [3:0] el, input logic ee, input int poke);
    exp_t e;
    int   n;
    @(negedge clk);
    e.value = ev;
    e.len   = el;
    e.npc   = pc + el;
    e.err   = ee;
    e.dcyc  = cyc + int'(el) + 2;
    sb.push_back(e);
    start       = 1'b1;
    pc_in       = pc;
    signed_mode = sgn;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy),      64'd1);
    chk("rom_addr_first",   64'(rom_addr),  64'(pc));
    chk("rom_extra",        64'(rom_extra), 64'd0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (poke == 1 && n == 1) begin
        start = 1'b1;
        pc_in = pc + 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    if (poke == 2) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_cleared", 64'(busy),  64'd0);
    chk("done_single",  64'(done),  64'd0);
    chk("value_held",   64'(value), 64'(ev));
    repeat ((poke != 0) ? 8 : 2) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    pc_in       = 4'd0;
    signed_mode = 1'b0;
    lo_b        = 4'd0;
    hi_b        = 4'd15;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_error",    64'(error),    64'd0);
    chk("rst_value",    64'(value),    64'd0);
    chk("rst_len",      64'(len),      64'd0);
    chk("rst_next_pc",  64'(next_pc),  64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    reset = 1'b0;

    mem[2] = 8'h05;
    run(4'd2, 1'b0, 32'd5, 4'd1, 1'b0, 0);

    mem[0] = 8'hE5; mem[1] = 8'h8E; mem[2] = 8'h26;
    run(4'd0, 1'b0, 32'd624485, 4'd3, 1'b0, 0);

    mem[0] = 8'h7F;
    run(4'd0, 1'b1, 32'hFFFF_FFFF, 4'd1, 1'b0, 0);
    run(4'd0, 1'b0, 32'h0000_007F, 4'd1, 1'b0, 0);

    mem[0] = 8'hC0; mem[1] = 8'hBB; mem[2] = 8'h78;
    run(4'd0, 1'b1, 32'hFFFE_1DC0, 4'd3, 1'b0, 0);

    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'hFF; mem[4] = 8'h0F;
    run(4'd0, 1'b0, 32'hFFFF_FFFF, 4'd5, 1'b0, 0);
    run(4'd0, 1'b1, 32'd0, 4'd5, 1'b1, 0);
    run(4'd0, 1'b0, 32'hFFFF_FFFF, 4'd5, 1'b0, 1);

    mem[4] = 8'h1F;
    run(4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 0);

    mem[4] = 8'h7F;
    run(4'd0, 1'b1, 32'hFFFF_FFFF, 4'd5, 1'b0, 0);
    run(4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 0);

    for (int i = 0; i < 5; i++) mem[i] = 8'h80;
    run(4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 0);

    mem[15] = 8'h81; mem[0] = 8'h01;
    run(4'd15, 1'b0, 32'd129, 4'd2, 1'b0, 0);

    hi_b = 4'd9;
    mem[8] = 8'h80; mem[9] = 8'h80; mem[10] = 8'h00;
    run(4'd8, 1'b0, 32'd0, 4'd3, 1'b1, 0);
    hi_b = 4'd15;

    mem[3] = 8'h2A;
    run(4'd3, 1'b0, 32'd42, 4'd1, 1'b0, 2);

    // Abort a 5-byte decode with reset partway through.
    for (int i = 0; i < 5; i++) mem[i] = 8'hFF;
    mem[4] = 8'h0F;
    @(negedge clk);
    start = 1'b1; pc_in = 4'd0; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy",     64'(busy),     64'd0);
    chk("abort_done",     64'(done),     64'd0);
    chk("abort_value",    64'(value),    64'd0);
    chk("abort_len",      64'(len),      64'd0);
    chk("abort_next_pc",  64'(next_pc),  64'd0);
    chk("abort_rom_addr", 64'(rom_addr), 64'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    mem[6] = 8'h96; mem[7] = 8'h01;
    run(4'd6, 1'b0, 32'd150, 4'd2, 1'b0, 0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/leb128_reader.md
Name: leb128_reader

Overview:
- Sequential fetch-and-decode stage directly downstream of the generic ROM (genrom). Reads a WebAssembly LEB128 immediate one byte per cycle.
- Given a start address, it drives the ROM address and extra ports and consumes the byte returned in the ROM data low lane.
- Accumulates a signed or unsigned integer and reports value, encoded length, next PC and error to the instruction decoder.

Parameters:
- AW, 4, ROM address width; must match the genrom AW.
- W, 32, decoded value width; only 32 and 64 are legal.
- MAXLEN, derived as ceil(W/7) (5 for W=32, 10 for W=64), maximum encoded bytes; localparam, not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin decode; sampled only in IDLE.
- pc_in  in  AW  address of first LEB128 byte.
- signed_mode  in  1  1 = sLEB128, 0 = uLEB128; latched on start.
- rom_addr  out  AW  to genrom addr; registered.
- rom_extra  out  4  to genrom extra; constant 0 (one byte per read).
- rom_data  in  8  genrom data[7:0].
- rom_error  in  1  genrom error, aligned with rom_data.
- busy  out  1  decode in progress.
- done  out  1  one-cycle pulse; result ports valid.
- error  out  1  one-cycle pulse coincident with done on failure.
- value  out  W  decoded value; held until next start.
- len  out  4  bytes consumed, 1..MAXLEN; held.
- next_pc  out  AW  pc_in+len, modulo 2^AW; held.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state IDLE; busy, done, error = 0; value, len, next_pc, rom_addr = 0. Reset mid-decode aborts the decode with no done pulse.
- ROM timing: one-cycle latency. Address presented at edge e yields rom_data/rom_error sampled at edge e+1.
- States:
  - IDLE: on start, latch pc_in, signed_mode; rom_addr<=pc_in; clear acc, idx; go WAIT.
  - WAIT: one cycle; rom_addr<=rom_addr+1; go DECODE.
  - DECODE: each edge, sample byte k, acc |= byte[6:0] << 7k, and rom_addr increments speculatively. Bytes fetched past the terminator are discarded.
- Timing: start at edge 0; byte k sampled at edge k+2. For an N-byte value, done is high in the cycle after edge N+1. busy is high from edge 0 through the done cycle inclusive.
- Termination (byte[7]==0, k<MAXLEN):
  - value<=acc, with bits at or above 7(k+1) zero-filled (unsigned) or filled with byte[6] (signed). Sign fill applies only when 7(k+1)<W.
  - len<=k+1, next_pc<=start pc+k+1, done=1, error=0, return to IDLE.
- Errors, all giving done=1, error=1, len=k+1, value=0, next_pc=start pc+k+1:
  - rom_error=1 at byte k: result comes from that byte, regardless of rom_data.
  - Byte k=MAXLEN-1 with byte[7]=1: overlong.
  - Final byte k=MAXLEN-1 with unused bits nonzero (unsigned) or not all equal to the sign bit (signed). The unused bits are byte[6:W-7(MAXLEN-1)].
- start while busy is ignored. start in the same cycle as done is ignored; start is accepted one cycle later.
- rom_addr wraps modulo 2^AW; wrapping is not an error, and genrom bounds checking reports out-of-range addresses.
- rom_extra is tied to 0 in all states.

Test Plan:
- Single byte: ROM[2]=0x05, unsigned, pc_in=2 -> done 3 cycles after start, value=5, len=1, next_pc=3, error=0.
- Multi-byte unsigned: ROM 0xE5 0x8E 0x26 at 0 -> value=32'd624485, len=3, next_pc=3, done at edge 4.
- Signed: 0x7F -> 0xFFFFFFFF, len=1; 0xC0 0xBB 0x78 -> 32'hFFFE1DC0 (-123456), len=3.
- Unsigned 5-byte limits:
  - 0xFF 0xFF 0xFF 0xFF 0x0F -> 0xFFFFFFFF, no error.
  - Same with last byte 0x1F -> error=1, value=0, len=5.
  - 0x80 x5 -> error (overlong) at len=5.
- Bounds: ROM lower_bound=0, upper_bound=9; bytes 0x80 0x80 at 8,9; pc_in=8 -> rom_error on byte 2 at address 10 -> error=1, len=3.
- Control:
  - start pulsed again while busy -> ignored, result unchanged.
  - reset asserted mid-decode -> next cycle busy=0, done never pulses, outputs zero.
  - New start then decodes normally.
